mc_ctrl_fsm: RTL and testbench

- Parametrised control unit for the multicycle MIPS datapath; replaces the fixed-width control FSM.
- Moore state register with asynchronous reset. Write enables are qualified by a memory ready handshake, so memory may have variable latency.
- Adds a wait-cycle timeout, correct JAL link write to $31, and a sticky fault state for illegal commands.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/mc_mem_wait_timer.sv | 33 +++
 rtl/mc_ctrl_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, commands,
// ALU operations and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EX_BR  = 4'd2,
      EX_JR  = 4'd3,
      EX_R   = 4'd4,
      EX_I   = 4'd5,
      MEM_RD = 4'd6,
      MEM_WR = 4'd7,
      WB_R   = 4'd8,
      WB_I   = 4'd9,
      WB_LW  = 4'd10,
      FAULT  = 4'd11
   } state_t;

   localparam int unsigned CMD_LW   = 0;
   localparam int unsigned CMD_SW   = 1;
   localparam int unsigned CMD_J    = 2;
   localparam int unsigned CMD_JR   = 3;
   localparam int unsigned CMD_JAL  = 4;
   localparam int unsigned CMD_BEQ  = 5;
   localparam int unsigned CMD_BNE  = 6;
   localparam int unsigned CMD_XORI = 7;
   localparam int unsigned CMD_ADDI = 8;
   localparam int unsigned CMD_ADD  = 9;
   localparam int unsigned CMD_SUB  = 10;
   localparam int unsigned CMD_SLT  = 11;

   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_XOR = 2;
   localparam int unsigned ALU_SLT = 3;

   localparam logic [1:0] PCSRC_ALU_RES = 2'd0;
   localparam logic [1:0] PCSRC_ALU     = 2'd1;
   localparam logic [1:0] PCSRC_J       = 2'd2;
   localparam logic [1:0] PCSRC_A       = 2'd3;

   localparam logic SRCA_PC = 1'b0;
   localparam logic SRCA_A  = 1'b1;

   localparam logic [1:0] SRCB_SXIS = 2'd0;
   localparam logic [1:0] SRCB_SXI  = 2'd1;
   localparam logic [1:0] SRCB_B    = 2'd2;
   localparam logic [1:0] SRCB_FOUR = 2'd3;

   localparam logic MEMIN_PC      = 1'b0;
   localparam logic MEMIN_ALU_RES = 1'b1;

   localparam logic [1:0] DST_RD = 2'd0;
   localparam logic [1:0] DST_RT = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] REGIN_MDR     = 2'd0;
   localparam logic [1:0] REGIN_ALU_RES = 2'd1;
   localparam logic [1:0] REGIN_PC      = 2'd2;

   function automatic logic is_mem_wait_state(input state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts consecutive not-ready cycles of an outstanding memory request and
// flags when the configured limit is reached (MEM_TIMEOUT=0 never expires).
module mc_mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TMR_W       = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   input  logic clear,
   output logic expired
);

   logic [TMR_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear || ready) begin
         r_cnt <= '0;
      end else if (active && (r_cnt != '1)) begin
         r_cnt <= r_cnt + TMR_W'(1);
      end
   end

   // A ready in the expiring cycle completes the access instead of faulting.
   always_comb begin
      expired = (MEM_TIMEOUT != 0) && active && !ready &&
                (r_cnt == TMR_W'(MEM_TIMEOUT));
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for the multicycle MIPS datapath with memory ready
// handshake, wait timeout and sticky fault state.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned CMD_W       = 4,
   parameter int unsigned ALU_OP_W    = 3,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TMR_W       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CMD_W-1:0]    cmd,
   input  logic                eq,
   input  logic                memReady,
   output logic                memReq,
   output logic [ALU_OP_W-1:0] aluOp,
   output logic [1:0]          pcSrc,
   output logic                aluSrcA,
   output logic [1:0]          aluSrcB,
   output logic                memIn,
   output logic [1:0]          dst,
   output logic [1:0]          regIn,
   output logic                pcWe,
   output logic                memWe,
   output logic                irWe,
   output logic                aWe,
   output logic                bWe,
   output logic                regWe,
   output logic                fault,
   output logic [3:0]          state
);

   state_t r_state;
   state_t w_next;
   logic   w_active;
   logic   w_clear;
   logic   w_expired;

   assign w_active = is_mem_wait_state(r_state);
   assign w_clear  = (w_next != r_state);

   mc_mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TMR_W      (TMR_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .active (w_active),
      .ready  (memReady),
      .clear  (w_clear),
      .expired(w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH: begin
            if (memReady)       w_next = DECODE;
            else if (w_expired) w_next = FAULT;
         end
         DECODE: begin
            case (cmd)
               CMD_W'(CMD_J), CMD_W'(CMD_JAL):                   w_next = FETCH;
               CMD_W'(CMD_JR):                                   w_next = EX_JR;
               CMD_W'(CMD_BEQ), CMD_W'(CMD_BNE):                 w_next = EX_BR;
               CMD_W'(CMD_ADD), CMD_W'(CMD_SUB), CMD_W'(CMD_SLT): w_next = EX_R;
               CMD_W'(CMD_LW), CMD_W'(CMD_SW),
               CMD_W'(CMD_ADDI), CMD_W'(CMD_XORI):               w_next = EX_I;
               default:                                          w_next = FAULT;
            endcase
         end
         EX_BR, EX_JR: w_next = FETCH;
         EX_R:         w_next = WB_R;
         EX_I: begin
            case (cmd)
               CMD_W'(CMD_ADDI), CMD_W'(CMD_XORI): w_next = WB_I;
               CMD_W'(CMD_LW):                     w_next = MEM_RD;
               CMD_W'(CMD_SW):                     w_next = MEM_WR;
               default:                            w_next = FAULT;
            endcase
         end
         MEM_RD: begin
            if (memReady)       w_next = WB_LW;
            else if (w_expired) w_next = FAULT;
         end
         MEM_WR: begin
            if (memReady)       w_next = FETCH;
            else if (w_expired) w_next = FAULT;
         end
         WB_R, WB_I, WB_LW: w_next = FETCH;
         FAULT:             w_next = FAULT;
         default:           w_next = FAULT;
      endcase
   end

   // Outputs are forced to zero while rst is high so no write can slip
   // through in the reset cycle even though the state already reads FETCH.
   always_comb begin
      memReq  = 1'b0;
      aluOp   = ALU_OP_W'(ALU_ADD);
      pcSrc   = PCSRC_ALU_RES;
      aluSrcA = SRCA_PC;
      aluSrcB = SRCB_SXIS;
      memIn   = MEMIN_PC;
      dst     = DST_RD;
      regIn   = REGIN_MDR;
      pcWe    = 1'b0;
      memWe   = 1'b0;
      irWe    = 1'b0;
      aWe     = 1'b0;
      bWe     = 1'b0;
      regWe   = 1'b0;
      fault   = 1'b0;
      if (!rst) begin
         case (r_state)
            FETCH: begin
               memReq  = 1'b1;
               memIn   = MEMIN_PC;
               aluSrcA = SRCA_PC;
               aluSrcB = SRCB_FOUR;
               aluOp   = ALU_OP_W'(ALU_ADD);
               pcSrc   = PCSRC_ALU;
               irWe    = memReady;
               pcWe    = memReady;
            end
            DECODE: begin
               aWe     = 1'b1;
               bWe     = 1'b1;
               aluSrcA = SRCA_PC;
               aluSrcB = SRCB_SXIS;
               aluOp   = ALU_OP_W'(ALU_ADD);
               if (cmd == CMD_W'(CMD_J) || cmd == CMD_W'(CMD_JAL)) begin
                  pcSrc = PCSRC_J;
                  pcWe  = 1'b1;
               end
               if (cmd == CMD_W'(CMD_JAL)) begin
                  regWe = 1'b1;
                  dst   = DST_RA;
                  regIn = REGIN_PC;
               end
            end
            EX_BR: begin
               aluSrcA = SRCA_A;
               aluSrcB = SRCB_B;
               aluOp   = ALU_OP_W'(ALU_SUB);
               pcSrc   = PCSRC_ALU_RES;
               pcWe    = (cmd == CMD_W'(CMD_BNE)) ? !eq : eq;
            end
            EX_JR: begin
               pcSrc = PCSRC_A;
               pcWe  = 1'b1;
            end
            EX_R: begin
               aluSrcA = SRCA_A;
               aluSrcB = SRCB_B;
               case (cmd)
                  CMD_W'(CMD_SUB): aluOp = ALU_OP_W'(ALU_SUB);
                  CMD_W'(CMD_SLT): aluOp = ALU_OP_W'(ALU_SLT);
                  default:         aluOp = ALU_OP_W'(ALU_ADD);
               endcase
            end
            EX_I: begin
               aluSrcA = SRCA_A;
               aluSrcB = SRCB_SXI;
               aluOp   = (cmd == CMD_W'(CMD_XORI)) ? ALU_OP_W'(ALU_XOR)
                                                   : ALU_OP_W'(ALU_ADD);
            end
            MEM_RD: begin
               memReq = 1'b1;
               memIn  = MEMIN_ALU_RES;
            end
            MEM_WR: begin
               memReq = 1'b1;
               memIn  = MEMIN_ALU_RES;
               memWe  = memReady;
            end
            WB_R: begin
               regWe = 1'b1;
               dst   = DST_RD;
               regIn = REGIN_ALU_RES;
            end
            WB_I: begin
               regWe = 1'b1;
               dst   = DST_RT;
               regIn = REGIN_ALU_RES;
            end
            WB_LW: begin
               regWe = 1'b1;
               dst   = DST_RT;
               regIn = REGIN_MDR;
            end
            FAULT:   fault = 1'b1;
            default: fault = 1'b1;
         endcase
      end
   end

   assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle vectors push expected
// outputs, a negedge monitor pops and compares against the DUT.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cmd;
   logic       eq;
   logic       memReady;
   logic       memReq;
   logic [2:0] aluOp;
   logic [1:0] pcSrc;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic       memIn;
   logic [1:0] dst;
   logic [1:0] regIn;
   logic       pcWe, memWe, irWe, aWe, bWe, regWe, fault;
   logic [3:0] state;

   mc_ctrl_fsm #(
      .CMD_W      (4),
      .ALU_OP_W   (3),
      .MEM_TIMEOUT(3),
      .TMR_W      (4)
   ) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .eq(eq), .memReady(memReady),
      .memReq(memReq), .aluOp(aluOp), .pcSrc(pcSrc), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .memIn(memIn), .dst(dst), .regIn(regIn),
      .pcWe(pcWe), .memWe(memWe), .irWe(irWe), .aWe(aWe), .bWe(bWe),
      .regWe(regWe), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   // we = {pcWe, memWe, irWe, aWe, bWe, regWe}
   typedef struct packed {
      logic [3:0] st;
      logic       mreq;
      logic [2:0] aop;
      logic [1:0] pcs;
      logic       sa;
      logic [1:0] sb;
      logic       min;
      logic [1:0] dst;
      logic [1:0] rin;
      logic [5:0] we;
      logic       flt;
   } exp_t;

   exp_t q[$];
   int   vid_q[$];
   int   checks = 0;
   int   failures = 0;
   int   vec = 0;

   function automatic exp_t E(input logic [3:0] st, input logic mreq,
                              input logic [2:0] aop, input logic [1:0] pcs,
                              input logic sa, input logic [1:0] sb,
                              input logic min, input logic [1:0] d,
                              input logic [1:0] rin, input logic [5:0] we,
                              input logic flt);
      exp_t e;
      e.st = st; e.mreq = mreq; e.aop = aop; e.pcs = pcs; e.sa = sa;
      e.sb = sb; e.min = min; e.dst = d; e.rin = rin; e.we = we; e.flt = flt;
      return e;
   endfunction

   function automatic exp_t FE(input logic r);
      return E(4'd0, 1'b1, 3'd0, 2'd1, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0,
               {r, 1'b0, r, 3'b000}, 1'b0);
   endfunction

   function automatic exp_t DE();
      return E(4'd1, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 6'b000110, 1'b0);
   endfunction

   function automatic exp_t ZR();
      return E(4'd0, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 6'b000000, 1'b0);
   endfunction

   function automatic exp_t FL();
      return E(4'd11, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 6'b000000, 1'b1);
   endfunction

   function automatic exp_t sample();
      exp_t g;
      g.st = state; g.mreq = memReq; g.aop = aluOp; g.pcs = pcSrc;
      g.sa = aluSrcA; g.sb = aluSrcB; g.min = memIn; g.dst = dst;
      g.rin = regIn; g.we = {pcWe, memWe, irWe, aWe, bWe, regWe};
      g.flt = fault;
      return g;
   endfunction

   task automatic cyc(input logic [3:0] c, input logic e, input logic r, input exp_t x);
      cmd = c; eq = e; memReady = r;
      q.push_back(x); vid_q.push_back(vec); vec++;
      @(posedge clk); #1;
   endtask

   task automatic rcyc();
      rst = 1'b1;
      cyc(4'd0, 1'b0, 1'b0, ZR());
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t x;
      exp_t g;
      int   id;
      if (q.size() > 0) begin
         x  = q.pop_front();
         id = vid_q.pop_front();
         g  = sample();
         checks++;
         if (g !== x) begin
            failures++;
            $display("FAIL vec%0d got=%h exp=%h", id, g, x);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t g;
      rst = 1'b1; cmd = '0; eq = 1'b0; memReady = 1'b0;
      @(posedge clk); #1;
      rcyc(); rcyc();
      // ADD / SUB / SLT
      cyc(4'd9, 0, 1, FE(1)); cyc(4'd9, 0, 1, DE());
      cyc(4'd9, 0, 1, E(4'd4, 0, 3'd0, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd9, 0, 1, E(4'd8, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd1, 6'b000001, 0));
      cyc(4'd10, 0, 1, FE(1)); cyc(4'd10, 0, 1, DE());
      cyc(4'd10, 0, 1, E(4'd4, 0, 3'd1, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd10, 0, 1, E(4'd8, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd1, 6'b000001, 0));
      cyc(4'd11, 0, 1, FE(1)); cyc(4'd11, 0, 1, DE());
      cyc(4'd11, 0, 1, E(4'd4, 0, 3'd3, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd11, 0, 1, E(4'd8, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd1, 6'b000001, 0));
      // LW with two wait cycles in FETCH and MEM_RD: 9 cycles
      cyc(4'd0, 0, 0, FE(0)); cyc(4'd0, 0, 0, FE(0)); cyc(4'd0, 0, 1, FE(1));
      cyc(4'd0, 0, 1, DE());
      cyc(4'd0, 0, 1, E(4'd5, 0, 3'd0, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd0, 0, 0, E(4'd6, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd0, 0, 0, E(4'd6, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd0, 0, 1, E(4'd6, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd0, 0, 1, E(4'd10, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd1, 2'd0, 6'b000001, 0));
      // branches: BEQ eq=1 taken, BNE eq=1 not, BNE eq=0 taken, BEQ eq=0 not
      cyc(4'd5, 0, 1, FE(1)); cyc(4'd5, 0, 1, DE());
      cyc(4'd5, 1, 1, E(4'd2, 0, 3'd1, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b100000, 0));
      cyc(4'd6, 0, 1, FE(1)); cyc(4'd6, 0, 1, DE());
      cyc(4'd6, 1, 1, E(4'd2, 0, 3'd1, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd6, 0, 1, FE(1)); cyc(4'd6, 0, 1, DE());
      cyc(4'd6, 0, 1, E(4'd2, 0, 3'd1, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b100000, 0));
      cyc(4'd5, 0, 1, FE(1)); cyc(4'd5, 0, 1, DE());
      cyc(4'd5, 0, 1, E(4'd2, 0, 3'd1, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b000000, 0));
      // JAL, J, JR
      cyc(4'd4, 0, 1, FE(1));
      cyc(4'd4, 0, 1, E(4'd1, 0, 3'd0, 2'd2, 0, 2'd0, 0, 2'd2, 2'd2, 6'b100111, 0));
      cyc(4'd2, 0, 1, FE(1));
      cyc(4'd2, 0, 1, E(4'd1, 0, 3'd0, 2'd2, 0, 2'd0, 0, 2'd0, 2'd0, 6'b100110, 0));
      cyc(4'd3, 0, 1, FE(1)); cyc(4'd3, 0, 1, DE());
      cyc(4'd3, 0, 1, E(4'd3, 0, 3'd0, 2'd3, 0, 2'd0, 0, 2'd0, 2'd0, 6'b100000, 0));
      // XORI, ADDI
      cyc(4'd7, 0, 1, FE(1)); cyc(4'd7, 0, 1, DE());
      cyc(4'd7, 0, 1, E(4'd5, 0, 3'd2, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd7, 0, 1, E(4'd9, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd1, 2'd1, 6'b000001, 0));
      cyc(4'd8, 0, 1, FE(1)); cyc(4'd8, 0, 1, DE());
      cyc(4'd8, 0, 1, E(4'd5, 0, 3'd0, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd8, 0, 1, E(4'd9, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd1, 2'd1, 6'b000001, 0));
      // SW with one wait cycle in MEM_WR
      cyc(4'd1, 0, 1, FE(1)); cyc(4'd1, 0, 1, DE());
      cyc(4'd1, 0, 1, E(4'd5, 0, 3'd0, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd1, 0, 0, E(4'd7, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd1, 0, 1, E(4'd7, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b010000, 0));
      // ready on the 4th FETCH cycle beats the timeout
      cyc(4'd2, 0, 0, FE(0)); cyc(4'd2, 0, 0, FE(0)); cyc(4'd2, 0, 0, FE(0));
      cyc(4'd2, 0, 1, FE(1));
      cyc(4'd2, 0, 1, E(4'd1, 0, 3'd0, 2'd2, 0, 2'd0, 0, 2'd0, 2'd0, 6'b100110, 0));
      // timeout in FETCH, FAULT is sticky
      cyc(4'd9, 0, 0, FE(0)); cyc(4'd9, 0, 0, FE(0)); cyc(4'd9, 0, 0, FE(0));
      cyc(4'd9, 0, 0, FE(0));
      cyc(4'd9, 0, 1, FL()); cyc(4'd2, 1, 0, FL()); cyc(4'd0, 0, 1, FL());
      rcyc();
      // illegal command
      cyc(4'd13, 0, 1, FE(1)); cyc(4'd13, 0, 1, DE());
      cyc(4'd5, 0, 1, FL()); cyc(4'd9, 0, 0, FL());
      rcyc();
      // timeout in MEM_RD
      cyc(4'd0, 0, 1, FE(1)); cyc(4'd0, 0, 1, DE());
      cyc(4'd0, 0, 1, E(4'd5, 0, 3'd0, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 6'b000000, 0));
      for (int i = 0; i < 4; i++)
         cyc(4'd0, 0, 0, E(4'd6, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd0, 0, 0, FL());
      rcyc();
      // asynchronous reset while MEM_WR is writing
      cyc(4'd1, 0, 1, FE(1)); cyc(4'd1, 0, 1, DE());
      cyc(4'd1, 0, 1, E(4'd5, 0, 3'd0, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 6'b000000, 0));
      cmd = 4'd1; eq = 1'b0; memReady = 1'b1;
      q.push_back(E(4'd7, 1, 3'd0, 2'd0, 0, 2'd0, 1, 2'd0, 2'd0, 6'b010000, 0));
      vid_q.push_back(vec); vec++;
      #6 rst = 1'b1;
      #1;
      checks++;
      if (memWe !== 1'b0) begin
         failures++;
         $display("FAIL async_rst_memWe got=%b exp=0", memWe);
      end
      checks++;
      if (state !== 4'd0) begin
         failures++;
         $display("FAIL async_rst_state got=%0d exp=0", state);
      end
      g = sample();
      checks++;
      if (g !== ZR()) begin
         failures++;
         $display("FAIL async_rst_outputs got=%h exp=%h", g, ZR());
      end
      @(posedge clk); #1;
      rcyc();
      cyc(4'd9, 0, 1, FE(1)); cyc(4'd9, 0, 1, DE());
      cyc(4'd9, 0, 1, E(4'd4, 0, 3'd0, 2'd0, 1, 2'd2, 0, 2'd0, 2'd0, 6'b000000, 0));
      cyc(4'd9, 0, 1, E(4'd8, 0, 3'd0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd1, 6'b000001, 0));
      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
